// File: rtl/draw_line.sv
// -----------------------------------------------------------------------------
// draw_line
// Rasterises one straight line into a framebuffer using Bresenham's
// integer algorithm. A line request is taken in IDLE. One cycle (INIT) sets up
// the deltas, and then one pixel is emitted per clock in DRAW until the end
// point has been written. Pixels outside the framebuffer still use their
// cycle, but with the write enable held low.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    draw request, accepted only in IDLE
//   x0, y0, x1, y1           line endpoints, captured with start
//   color                    pixel value, captured with start
//   we, addr_write, data_in  registered framebuffer write port
//   busy                     high while the line is set up or drawn
//   done                     one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module draw_line #(
    parameter int CORDW  = 8,
    parameter int FB_W   = 16,
    parameter int FB_H   = 16,
    parameter int ADDRW  = 8,
    parameter int COLORW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CORDW-1:0]  x0,
    input  logic [CORDW-1:0]  y0,
    input  logic [CORDW-1:0]  x1,
    input  logic [CORDW-1:0]  y1,
    input  logic [COLORW-1:0] color,
    output logic              we,
    output logic [ADDRW-1:0]  addr_write,
    output logic [COLORW-1:0] data_in,
    output logic              busy,
    output logic              done
);

    // Two extra bits hold the sign and the doubled error term without overflow.
    localparam int SW = CORDW + 2;
    localparam logic [CORDW-1:0] ONE = CORDW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CORDW-1:0]   x0_q, y0_q, x1_q, y1_q;
    logic [CORDW-1:0]   x0_d, y0_d, x1_d, y1_d;
    logic [COLORW-1:0]  color_q, color_d;
    logic [CORDW-1:0]   x_q, y_q, x_d, y_d;
    logic signed [SW-1:0] dx_q, dy_q, err_q;
    logic signed [SW-1:0] dx_d, dy_d, err_d;
    logic               sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;
    logic               we_q, we_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic [COLORW-1:0]  data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic signed [SW-1:0] diff_x_s, diff_y_s, abs_x_s, abs_y_s, e2_s;

    // A pixel is in the framebuffer when both coordinates are in range.
    function automatic logic in_fb(input logic [CORDW-1:0] px, input logic [CORDW-1:0] py);
        return (32'(px) < 32'(FB_W)) && (32'(py) < 32'(FB_H));
    endfunction

    // Row-major address. The arithmetic is modulo 2^ADDRW, so the result is the truncated address.
    function automatic logic [ADDRW-1:0] pix_addr(input logic [CORDW-1:0] px, input logic [CORDW-1:0] py);
        return ADDRW'(py) * ADDRW'(FB_W) + ADDRW'(px);
    endfunction

    assign diff_x_s = $signed(SW'(x1_q)) - $signed(SW'(x0_q));
    assign diff_y_s = $signed(SW'(y1_q)) - $signed(SW'(y0_q));
    assign abs_x_s  = diff_x_s[SW-1] ? -diff_x_s : diff_x_s;
    assign abs_y_s  = diff_y_s[SW-1] ? -diff_y_s : diff_y_s;
    assign e2_s     = err_q <<< 1;

    // Next-state, stepping and write-port logic.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        color_d  = color_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    color_d = color;
                    x_d     = x0;
                    y_d     = y0;
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                dx_d     = abs_x_s;
                dy_d     = -abs_y_s;
                err_d    = abs_x_s - abs_y_s;
                sx_neg_d = (x1_q < x0_q);
                sy_neg_d = (y1_q < y0_q);
                // Register the first pixel now so that it is visible in the first DRAW cycle.
                we_d     = in_fb(x_q, y_q);
                if (in_fb(x_q, y_q)) begin
                    addr_d = pix_addr(x_q, y_q);
                    data_d = color_q;
                end else begin
                    addr_d = addr_q;
                end
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if ((x_q == x1_q) && (y_q == y1_q)) begin
                    state_d = S_DONE;
                end else begin
                    // Both corrections use the same e2, which is taken before err is updated.
                    if (e2_s >= dy_q) begin
                        err_d = err_d + dy_q;
                        x_d   = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
                    end else begin
                        x_d   = x_q;
                    end
                    if (e2_s <= dx_q) begin
                        err_d = err_d + dx_q;
                        y_d   = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
                    end else begin
                        y_d   = y_q;
                    end
                    we_d = in_fb(x_d, y_d);
                    if (in_fb(x_d, y_d)) begin
                        addr_d = pix_addr(x_d, y_d);
                        data_d = color_q;
                    end else begin
                        addr_d = addr_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_INIT) || (state_d == S_DRAW);
        done_d = (state_d == S_DONE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers. Reset ends any line that is being drawn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign we         = we_q;
    assign addr_write = addr_q;
    assign data_in    = data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_draw_line.sv
// -----------------------------------------------------------------------------
// tb_draw_line
// Self-checking bench for draw_line. Expected pixel cycles (write enable and
// address) are queued when a line is requested. They are popped and compared
// one per clock while the DUT draws.
// -----------------------------------------------------------------------------
module tb_draw_line;

    localparam int CORDW  = 8;
    localparam int FB_W   = 16;
    localparam int FB_H   = 16;
    localparam int ADDRW  = 8;
    localparam int COLORW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CORDW-1:0]  x0, y0, x1, y1;
    logic [COLORW-1:0] color;
    logic              we;
    logic [ADDRW-1:0]  addr_write;
    logic [COLORW-1:0] data_in;
    logic              busy;
    logic              done;

    typedef struct {
        bit we;
        int addr;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_addr = 0;

    draw_line #(
        .CORDW(CORDW), .FB_W(FB_W), .FB_H(FB_H), .ADDRW(ADDRW), .COLORW(COLORW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .we(we), .addr_write(addr_write), .data_in(data_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit pwe, input int paddr);
        pix_t p;
        p.we   = pwe;
        p.addr = paddr;
        exp_q.push_back(p);
    endtask

    // Reference rasteriser written with plain integers.
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, dx, dy, sx, sy, err, e2;
        x   = ax0;
        y   = ay0;
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax1 >= ax0) ? 1 : -1;
        sy  = (ay1 >= ay0) ? 1 : -1;
        err = dx + dy;
        forever begin
            push((x < FB_W) && (y < FB_H), (y * FB_W + x) % 256);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Request one line and check every cycle until the done pulse. The cycle count is fixed.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input bit inject);
        int   n;
        pix_t p;
        n = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        x0 = ax0[7:0]; y0 = ay0[7:0]; x1 = ax1[7:0]; y1 = ay1[7:0];
        color = col[11:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        x0 = 8'hA5; y0 = 8'h5A; x1 = 8'h3C; y1 = 8'hC3; color = 12'hFFF;
        @(negedge clk);
        check("init_busy", busy, 1);
        check("init_we", we, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p = exp_q.pop_front();
            check("pix_we", we, p.we);
            if (p.we) begin
                check("pix_addr", addr_write, p.addr);
                check("pix_data", data_in, col);
                last_addr = p.addr;
            end else begin
                check("hold_addr", addr_write, last_addr);
            end
            check("pix_busy", busy, 1);
            check("pix_done", done, 0);
            if (inject && i == 1) begin
                start = 1'b1;
                x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_we", we, 0);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        rst = 1'b1; start = 1'b0;
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0; color = 12'h000;
        #1;
        check("rst_we", we, 0);
        check("rst_addr", addr_write, 0);
        check("rst_data", data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Horizontal line, reversed line, diagonal line, steep line, and a single point. These run back to back.
        push(1, 'h00); push(1, 'h01); push(1, 'h02); push(1, 'h03);
        run_line(0, 0, 3, 0, 'h123, 1'b0);
        push(1, 'h03); push(1, 'h02); push(1, 'h01); push(1, 'h00);
        run_line(3, 0, 0, 0, 'h321, 1'b0);
        push(1, 'h00); push(1, 'h11); push(1, 'h22); push(1, 'h33);
        run_line(0, 0, 3, 3, 'hABC, 1'b0);
        push(1, 'h00); push(1, 'h10); push(1, 'h21); push(1, 'h31);
        run_line(0, 0, 1, 3, 'h456, 1'b0);
        push(1, 'h55);
        run_line(5, 5, 5, 5, 'h789, 1'b0);

        // Clipped line. A start pulse in the middle of the line must be ignored.
        push(1, 'h0E); push(1, 'h0F); push(0, 0); push(0, 0);
        run_line(14, 0, 17, 0, 'h0F0, 1'b1);
        @(negedge clk);
        check("no_queued_start", busy, 0);

        // Reset during the second pixel of (0,0)->(7,0).
        @(negedge clk);
        start = 1'b1; x0 = 8'd0; y0 = 8'd0; x1 = 8'd7; y1 = 8'd0; color = 12'h5A5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_pix_we", we, 1);
        check("mid_pix_addr", addr_write, 'h01);
        rst = 1'b1;
        #1;
        check("abort_we", we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        last_addr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_no_we", we, 0);
        end
        model(2, 9, 6, 9);
        run_line(2, 9, 6, 9, 'h0AA, 1'b0);

        // Random lines, some of them partly outside the framebuffer.
        for (int k = 0; k < 8; k++) begin
            rx0 = $urandom_range(0, 19); ry0 = $urandom_range(0, 19);
            rx1 = $urandom_range(0, 19); ry1 = $urandom_range(0, 19);
            model(rx0, ry0, rx1, ry1);
            run_line(rx0, ry0, rx1, ry1, $urandom_range(0, 4095), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_line.md
DRAW_LINE -- requirements
Module: draw_line

Interface
REQ-001 SHALL have parameter CORDW, default 8, meaning coordinate width in bits (unsigned).
REQ-002 SHALL have parameter FB_W, default 16, meaning framebuffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 16, meaning framebuffer height in pixels.
REQ-004 SHALL have parameter ADDRW, default 8, meaning framebuffer address width.
REQ-005 SHALL have parameter COLORW, default 12, meaning pixel data width.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  request to draw one line; sampled only in IDLE.
REQ-009 SHALL have ports x0, y0, x1, y1  input  CORDW each  line endpoints, sampled with start.
REQ-010 SHALL have port color  input  COLORW  pixel value, sampled with start.
REQ-011 SHALL have port we  output  1  framebuffer write enable, registered.
REQ-012 SHALL have port addr_write  output  ADDRW  framebuffer write address, registered.
REQ-013 SHALL have port data_in  output  COLORW  framebuffer write data, registered.
REQ-014 SHALL have port busy  output  1  high in INIT and DRAW.
REQ-015 SHALL have port done  output  1  single-cycle pulse after the last pixel.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, DRAW, DONE; IDLE->INIT on start, INIT->DRAW unconditionally, DRAW->DONE after final pixel, DONE->IDLE unconditionally.
REQ-017 SHALL latch x0, y0, x1, y1, color on the edge where start=1 in IDLE; start in any other state SHALL be ignored, not queued.
REQ-018 SHALL in INIT compute dx=|x1-x0|, dy=-|y1-y0|, sx=+1/-1, sy=+1/-1 (+1 when end>=start), err=dx+dy, using signed width CORDW+2.
REQ-019 SHALL in DRAW emit the current pixel (x,y) each cycle, then step: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy (both adjustments from same e2).
REQ-020 SHALL treat the pixel where x==x1 and y==y1 as final; it SHALL be emitted, then FSM moves to DONE.
REQ-021 SHALL produce exactly max(|x1-x0|,|y1-y0|)+1 pixel cycles, contiguous, one per clk, no gaps.
REQ-022 SHALL set addr_write = y*FB_W + x, truncated to ADDRW bits, and data_in = latched color, for every emitted pixel.
REQ-023 SHALL drive we=1 for an emitted pixel only when x<FB_W and y<FB_H; out-of-bounds pixels SHALL consume their cycle with we=0.
REQ-024 SHALL hold we=0 in IDLE, INIT, DONE; addr_write and data_in hold last value when we=0.
REQ-025 SHALL have latency: start sampled at edge N -> INIT in cycle N+1 -> first pixel we=1 in cycle N+2.
REQ-026 SHALL assert done for exactly the one cycle following the final pixel cycle; busy=0 in that cycle.
REQ-027 SHALL accept a new start in the IDLE cycle immediately after DONE (back-to-back lines, one idle cycle minimum).
REQ-028 SHALL handle x0==x1 and y0==y1 as a one-pixel line.

Reset
REQ-029 SHALL on rst force state IDLE, we=0, addr_write=0, data_in=0, busy=0, done=0, internal coordinates and err=0, asynchronously.
REQ-030 SHALL abort any line in progress on rst with no further writes; no done pulse for the aborted line.

Verification
REQ-031 SHALL cover horizontal: start (0,0)->(3,0) color 0x123 -> we=1 four consecutive cycles, addr 0x00,0x01,0x02,0x03, data 0x123, done next cycle.
REQ-032 SHALL cover reversed and diagonal: (3,0)->(0,0) -> addr 0x03,0x02,0x01,0x00; (0,0)->(3,3) -> addr 0x00,0x11,0x22,0x33.
REQ-033 SHALL cover steep: (0,0)->(1,3) color 0x456 -> addr 0x00,0x10,0x21,0x31, then done.
REQ-034 SHALL cover single point: (5,5) color 0x789 -> one write addr 0x55 in cycle N+2, done in N+3.
REQ-035 SHALL cover clipping and busy: FB_W=16, (14,0)->(17,0) -> we pattern 1,1,0,0 over 4 pixel cycles; start pulsed mid-line -> ignored, pixel stream unchanged.
REQ-036 SHALL cover reset mid-line: rst during 2nd pixel of (0,0)->(7,0) -> we=0, busy=0 immediately, no done; subsequent start draws normally.
